// File: rtl/pipe_chain_ctrl.sv
// DEPTH-stage valid/allowin/ready_go pipeline shell with multi-stage flush
// and a RAW hazard lookup over every in-flight stage.
module pipe_chain_ctrl #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 4,
   parameter int DEST_W = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_allowin,
   input  logic [WIDTH-1:0]         in_bus,
   input  logic                     in_gr_we,
   input  logic [DEST_W-1:0]        in_dest,
   input  logic [DEPTH-1:0]         stage_ready_go,
   input  logic [DEPTH-1:0]         flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_bus,
   output logic [DEPTH-1:0]         stage_valid,
   output logic [DEPTH-1:0]         stage_gr_we,
   output logic [DEPTH*DEST_W-1:0]  stage_dest,
   input  logic [DEST_W-1:0]        rs1,
   input  logic [DEST_W-1:0]        rs2,
   output logic [DEPTH-1:0]         raw_sel1,
   output logic [DEPTH-1:0]         raw_sel2
);

   logic [DEPTH-1:0]              r_valid;
   logic [DEPTH-1:0][WIDTH-1:0]   r_bus;
   logic [DEPTH-1:0]              r_we;
   logic [DEPTH-1:0][DEST_W-1:0]  r_dest;

   logic [DEPTH-1:0]              w_kill_ge;
   logic [DEPTH:0]                w_allowin;
   logic [DEPTH-1:0]              w_inc;
   logic [DEPTH-1:0][WIDTH-1:0]   w_src_bus;
   logic [DEPTH-1:0]              w_src_we;
   logic [DEPTH-1:0][DEST_W-1:0]  w_src_dest;
   logic [DEPTH-1:0]              w_m1;
   logic [DEPTH-1:0]              w_m2;

   // kill_ge and allowin both ripple from the oldest stage toward the youngest
   always_comb begin
      w_kill_ge              = '0;
      w_allowin              = '0;
      w_kill_ge[DEPTH-1]     = flush[DEPTH-1];
      w_allowin[DEPTH]       = out_ready;
      for (int i = DEPTH-2; i >= 0; i--)
         w_kill_ge[i] = w_kill_ge[i+1] | flush[i];
      for (int i = DEPTH-1; i >= 0; i--)
         w_allowin[i] = !r_valid[i] | (stage_ready_go[i] & w_allowin[i+1]);
   end

   always_comb begin
      w_inc         = '0;
      w_src_bus     = '0;
      w_src_we      = '0;
      w_src_dest    = '0;
      w_inc[0]      = in_valid & !w_kill_ge[0];
      w_src_bus[0]  = in_bus;
      w_src_we[0]   = in_gr_we;
      w_src_dest[0] = in_dest;
      for (int i = 1; i < DEPTH; i++) begin
         w_inc[i]      = r_valid[i-1] & stage_ready_go[i-1] & !w_kill_ge[i-1];
         w_src_bus[i]  = r_bus[i-1];
         w_src_we[i]   = r_we[i-1];
         w_src_dest[i] = r_dest[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
         r_bus   <= '0;
         r_we    <= '0;
         r_dest  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_kill_ge[i])
               r_valid[i] <= 1'b0;
            else if (w_allowin[i])
               r_valid[i] <= w_inc[i];
            // w_inc already excludes killed sources, so a killed stage never loads
            if (w_allowin[i] && w_inc[i]) begin
               r_bus[i]  <= w_src_bus[i];
               r_we[i]   <= w_src_we[i];
               r_dest[i] <= w_src_dest[i];
            end
         end
      end
   end

   assign in_allowin  = w_allowin[0] & !w_kill_ge[0];
   assign out_valid   = r_valid[DEPTH-1] & stage_ready_go[DEPTH-1] & !flush[DEPTH-1];
   assign out_bus     = r_bus[DEPTH-1];
   assign stage_valid = r_valid;
   assign stage_gr_we = r_valid & r_we;
   assign stage_dest  = r_dest;

   always_comb begin
      w_m1     = '0;
      w_m2     = '0;
      raw_sel1 = '0;
      raw_sel2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_m1[i] = r_valid[i] & r_we[i] & (r_dest[i] == rs1) & (rs1 != '0);
         w_m2[i] = r_valid[i] & r_we[i] & (r_dest[i] == rs2) & (rs2 != '0);
      end
      // scan oldest to youngest so the youngest match overwrites
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (w_m1[i]) begin
            raw_sel1    = '0;
            raw_sel1[i] = 1'b1;
         end
         if (w_m2[i]) begin
            raw_sel2    = '0;
            raw_sel2[i] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_chain_ctrl.sv
// Randomized + directed bench for pipe_chain_ctrl against a cycle-level
// reference model of the stage handshake, flush and hazard rules.
module tb_pipe_chain_ctrl;
   localparam int D  = 4;
   localparam int W  = 32;
   localparam int DW = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_allowin;
   logic [W-1:0]    in_bus;
   logic            in_gr_we;
   logic [DW-1:0]   in_dest;
   logic [D-1:0]    stage_ready_go;
   logic [D-1:0]    flush;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    out_bus;
   logic [D-1:0]    stage_valid;
   logic [D-1:0]    stage_gr_we;
   logic [D*DW-1:0] stage_dest;
   logic [DW-1:0]   rs1, rs2;
   logic [D-1:0]    raw_sel1, raw_sel2;

   pipe_chain_ctrl #(.WIDTH(W), .DEPTH(D), .DEST_W(DW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(in_allowin),
      .in_bus(in_bus), .in_gr_we(in_gr_we), .in_dest(in_dest),
      .stage_ready_go(stage_ready_go), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_bus(out_bus), .stage_valid(stage_valid),
      .stage_gr_we(stage_gr_we), .stage_dest(stage_dest), .rs1(rs1), .rs2(rs2),
      .raw_sel1(raw_sel1), .raw_sel2(raw_sel2));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [D-1:0]  m_v;
   logic [W-1:0]  m_bus [D];
   logic          m_we  [D];
   logic [DW-1:0] m_dest[D];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_v = '0;
      for (int i = 0; i < D; i++) begin
         m_bus[i] = '0; m_we[i] = 1'b0; m_dest[i] = '0;
      end
   endtask

   // compare all outputs to the model, then advance the model one clock
   task automatic step();
      logic [D:0]    al;
      logic [D-1:0]  kill, inc, nv, swe, e1, e2;
      logic [D*DW-1:0] sd;
      logic [W-1:0]  nb [D];
      logic          nwe[D];
      logic [DW-1:0] nd [D];
      #1;
      for (int j = 0; j < D; j++) kill[j] = (flush >> j) != 0;
      al[D] = out_ready;
      for (int i = D-1; i >= 0; i--) al[i] = !m_v[i] || (stage_ready_go[i] && al[i+1]);
      e1 = '0; e2 = '0;
      for (int i = 0; i < D; i++) begin
         swe[i] = m_v[i] && m_we[i];
         sd[i*DW +: DW] = m_dest[i];
         if (e1 == 0 && swe[i] && m_dest[i] == rs1 && rs1 != 0) e1 = D'(1) << i;
         if (e2 == 0 && swe[i] && m_dest[i] == rs2 && rs2 != 0) e2 = D'(1) << i;
      end
      chk("in_allowin", 64'(in_allowin), 64'(al[0] && !kill[0]));
      chk("out_valid", 64'(out_valid), 64'(m_v[D-1] && stage_ready_go[D-1] && !flush[D-1]));
      chk("out_bus", 64'(out_bus), 64'(m_bus[D-1]));
      chk("stage_valid", 64'(stage_valid), 64'(m_v));
      chk("stage_gr_we", 64'(stage_gr_we), 64'(swe));
      chk("stage_dest", 64'(stage_dest), 64'(sd));
      chk("raw_sel1", 64'(raw_sel1), 64'(e1));
      chk("raw_sel2", 64'(raw_sel2), 64'(e2));
      for (int i = 0; i < D; i++) begin
         if (i == 0) inc[i] = in_valid && !kill[0];
         else        inc[i] = m_v[i-1] && stage_ready_go[i-1] && !kill[i-1];
         nv[i] = kill[i] ? 1'b0 : (al[i] ? inc[i] : m_v[i]);
         nb[i] = m_bus[i]; nwe[i] = m_we[i]; nd[i] = m_dest[i];
         if (al[i] && inc[i]) begin
            if (i == 0) begin
               nb[i] = in_bus; nwe[i] = in_gr_we; nd[i] = in_dest;
            end else begin
               nb[i] = m_bus[i-1]; nwe[i] = m_we[i-1]; nd[i] = m_dest[i-1];
            end
         end
      end
      @(posedge clk);
      if (reset) m_reset();
      else begin
         m_v = nv;
         for (int i = 0; i < D; i++) begin
            m_bus[i] = nb[i]; m_we[i] = nwe[i]; m_dest[i] = nd[i];
         end
      end
      @(negedge clk);
   endtask

   task automatic push(input logic [W-1:0] b, input logic we, input logic [DW-1:0] d);
      in_valid = 1'b1; in_bus = b; in_gr_we = we; in_dest = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic fill_hazard(input logic we_z);
      stage_ready_go = '1; out_ready = 1'b1;
      push(32'h51, 1'b1, 5'd5);
      push(32'h52, 1'b0, 5'd7);
      push(32'h53, we_z, 5'd5);
      step();
      stage_ready_go = '0; out_ready = 1'b0;
   endtask

   logic [W-1:0] got_q[$];
   int n;

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_bus = '0; in_gr_we = 1'b0; in_dest = '0;
      stage_ready_go = '1; flush = '0; out_ready = 1'b1; rs1 = '0; rs2 = '0;
      m_reset();

      // reset state
      @(negedge clk); #1;
      chk("rst_sv", 64'(stage_valid), 64'h0);
      chk("rst_ov", 64'(out_valid), 64'h0);
      chk("rst_allow", 64'(in_allowin), 64'h1);
      flush = 4'b0100; #1;
      chk("rst_allow_fl", 64'(in_allowin), 64'h0);
      flush = '0; in_valid = 1'b1; in_bus = 32'hDEAD;
      step(); step();
      reset = 1'b0; in_valid = 1'b0;

      // latency and throughput
      for (int k = 0; k < 8; k++) begin
         in_valid = (k < 3); in_bus = 32'h11 * (k + 1); in_gr_we = 1'b0;
         #1;
         chk("lat_v", 64'(out_valid), 64'(k >= 4 && k <= 6));
         if (k >= 4 && k <= 6) chk("lat_bus", 64'(out_bus), 64'(32'h11 * (k - 3)));
         step();
      end
      in_valid = 1'b0;

      // full chain backpressure, then in-order drain
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) push(32'hA0 + k, 1'b0, 5'd0);
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_bus = 32'hEE; #1;
         chk("bp_allow", 64'(in_allowin), 64'h0);
         chk("bp_sv", 64'(stage_valid), 64'hF);
         chk("bp_bus", 64'(out_bus), 64'hA0);
         step();
      end
      out_ready = 1'b1; in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("dr_v", 64'(out_valid), 64'h1);
         chk("dr_bus", 64'(out_bus), 64'(32'hA0 + k));
         step();
      end
      #1 chk("dr_empty", 64'(stage_valid), 64'h0);

      // partial flush of stages 0..1
      for (int k = 0; k < 3; k++) push(32'hB1 + k, 1'b0, 5'd0);
      flush = 4'b0010; in_valid = 1'b1; in_bus = 32'hCC; #1;
      chk("fl_allow", 64'(in_allowin), 64'h0);
      step();
      flush = '0; in_valid = 1'b0; #1;
      chk("fl_sv", 64'(stage_valid), 64'h8);
      chk("fl_bus", 64'(out_bus), 64'hB1);
      chk("fl_ov", 64'(out_valid), 64'h1);
      step();
      #1 chk("fl_empty", 64'(stage_valid), 64'h0);

      // stalled stage 1 creates a bubble downstream and holds stage 0
      push(32'hD1, 1'b0, 5'd0);
      stage_ready_go = 4'b1101;
      push(32'hD2, 1'b0, 5'd0);
      in_valid = 1'b1; in_bus = 32'hD3; #1;
      chk("bb_allow", 64'(in_allowin), 64'h0);
      chk("bb_sv", 64'(stage_valid), 64'h3);
      step();
      #1 chk("bb_sv2", 64'(stage_valid), 64'h3);
      stage_ready_go = '1; in_valid = 1'b0;
      got_q.delete();
      for (int k = 0; k < 8; k++) begin
         #1; if (out_valid) got_q.push_back(out_bus);
         step();
      end
      chk("bb_n", 64'(got_q.size()), 64'd2);
      if (got_q.size() == 2) begin
         chk("bb_0", 64'(got_q[0]), 64'hD1);
         chk("bb_1", 64'(got_q[1]), 64'hD2);
      end

      // hazard lookup
      fill_hazard(1'b1);
      rs1 = 5'd5; rs2 = 5'd0; #1;
      chk("hz1_young", 64'(raw_sel1), 64'h2);
      chk("hz2_zero", 64'(raw_sel2), 64'h0);
      rs2 = 5'd7; #1;
      chk("hz2_nowe", 64'(raw_sel2), 64'h0);
      step();
      stage_ready_go = '1; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) step();
      fill_hazard(1'b0);
      rs1 = 5'd5; #1;
      chk("hz1_old", 64'(raw_sel1), 64'h8);
      step();
      stage_ready_go = '1; out_ready = 1'b1; rs1 = '0; rs2 = '0;
      for (int k = 0; k < 4; k++) step();

      // asynchronous reset mid-traffic
      for (int k = 0; k < 5; k++) push(32'hE0 + k, 1'b1, 5'd3);
      in_valid = 1'b1; in_bus = 32'hE9;
      @(posedge clk); #2 reset = 1'b1; #1;
      chk("ar_sv", 64'(stage_valid), 64'h0);
      chk("ar_ov", 64'(out_valid), 64'h0);
      m_reset();
      @(negedge clk);
      step();
      reset = 1'b0;
      in_valid = 1'b1; in_bus = 32'hF0; n = 0;
      while (n < 20) begin
         #1;
         if (out_valid === 1'b1 && out_bus == 32'hF0) break;
         step();
         in_valid = 1'b0;
         n++;
      end
      chk("ar_lat", 64'(n), 64'd4);
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) step();

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         in_valid = ($urandom % 4) != 0;
         in_bus = $urandom; in_gr_we = $urandom % 2; in_dest = DW'($urandom % 4);
         stage_ready_go = D'($urandom | $urandom);
         flush = (($urandom % 8) == 0) ? D'(1) << ($urandom % D) : '0;
         out_ready = ($urandom % 4) != 0;
         rs1 = DW'($urandom % 4); rs2 = DW'($urandom % 4);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
